// File: rtl/pulse_handshake_tx.sv
// Source-domain transmitter for a four-phase req/ack CDC: counts pending event pulses
// and delivers them one by one as full handshakes. Optional timeout: PULSE_TX_TIMEOUT_EN.
module pulse_handshake_tx #(
   parameter int CNT_W       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int TO_CYCLES   = 255
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             din,
   input  logic             ack,
   output logic             req,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] pending,
   output logic             overflow,
   output logic             timeout_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      REL  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] PEND_MAX = '1;
   localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

   if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || CNT_W < 1 || TO_CYCLES < 1) begin : g_bad_param
      $error("pulse_handshake_tx: illegal parameter value");
   end

   state_t             state, state_nxt;
   logic               req_nxt, done_nxt, overflow_nxt;
   logic [CNT_W-1:0]   pending_nxt;
   logic               launch, inc, to_hit;
   logic [SYNC_STAGES-1:0] ack_sync;
   logic               ack_s;

   // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ack_sync <= '0;
      end else begin
         ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack};
      end
   end

   assign ack_s = ack_sync[SYNC_STAGES-1];

   // NOTE: every signal driven here gets a default first, so no latch can be inferred.
   always_comb begin
      state_nxt = state;
      req_nxt   = req;
      done_nxt  = 1'b0;
      launch    = 1'b0;
      case (state)
         IDLE: begin
            if (pending != '0 || din) begin
               launch    = 1'b1;
               state_nxt = REQ;
               req_nxt   = 1'b1;
            end
         end
         REQ: begin
            if (ack_s) begin
               state_nxt = REL;
               req_nxt   = 1'b0;
            end
         end
         REL: begin
            if (!ack_s) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            req_nxt   = 1'b0;
         end
      endcase

      overflow_nxt = din && (pending == PEND_MAX) && !launch;
      inc          = din && !overflow_nxt;
      case ({inc, launch})
         2'b10:   pending_nxt = pending + PEND_ONE;
         2'b01:   pending_nxt = pending - PEND_ONE;
         default: pending_nxt = pending;
      endcase

      // An abandoned handshake discards everything queued, including this cycle's event.
      if (to_hit) begin
         state_nxt    = IDLE;
         req_nxt      = 1'b0;
         done_nxt     = 1'b0;
         pending_nxt  = '0;
         overflow_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         req      <= 1'b0;
         done     <= 1'b0;
         pending  <= '0;
         overflow <= 1'b0;
      end else begin
         state    <= state_nxt;
         req      <= req_nxt;
         done     <= done_nxt;
         pending  <= pending_nxt;
         overflow <= overflow_nxt;
      end
   end

   assign busy = (state != IDLE);

`ifdef PULSE_TX_TIMEOUT_EN
   localparam int TO_W = $clog2(TO_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);
   localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

   logic [TO_W-1:0] to_cnt;

   // Fires on the TO_CYCLES-th edge spent in the same busy state.
   assign to_hit = (state != IDLE) && (to_cnt == TO_LAST);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         to_cnt      <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (state == IDLE || state_nxt != state) begin
            to_cnt <= '0;
         end else begin
            to_cnt <= to_cnt + TO_ONE;
         end
         if (to_hit) begin
            timeout_err <= 1'b1;
         end
      end
   end
`else
   assign to_hit      = 1'b0;
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_handshake_tx.sv
// Self-checking bench for pulse_handshake_tx: directed table, hand sequences for
// saturation/reset/timeout corners, and random traffic against an event-level model.
module tb_pulse_handshake_tx;

   localparam int SYNC    = 2;
   localparam int TO      = 16;
   localparam int MAX_PND = 15;

   logic       clk = 1'b0;
   logic       rstn;
   logic       din;
   logic       ack = 1'b0;
   logic       req, busy, done, overflow, timeout_err;
   logic [3:0] pending;

   logic       din2, ack2;
   logic       req2, busy2, done2, overflow2, timeout_err2;
   logic [1:0] pending2;

   logic       auto_ack;
   logic       ack_man;
   int         ack_dly = 0;

   int n_checks = 0;
   int n_errors = 0;
   int rises = 0, dones = 0, rises2 = 0, dones2 = 0;
   logic req_q = 1'b0, req2_q = 1'b0;

   bit model_on;
   bit m_busy, m_want, m_req, m_done, m_ovf;
   int m_pend;
   bit ackq[$];

   typedef struct {
      logic       d;
      logic       a;
      logic       e_req;
      logic       e_busy;
      logic       e_done;
      logic [3:0] e_pend;
   } vec_t;
   vec_t tbl[10];

   pulse_handshake_tx #(.CNT_W(4), .SYNC_STAGES(SYNC), .TO_CYCLES(TO)) dut (
      .clk(clk), .rstn(rstn), .din(din), .ack(ack), .req(req), .busy(busy),
      .done(done), .pending(pending), .overflow(overflow), .timeout_err(timeout_err)
   );

   pulse_handshake_tx #(.CNT_W(2), .SYNC_STAGES(SYNC), .TO_CYCLES(TO)) dut_small (
      .clk(clk), .rstn(rstn), .din(din2), .ack(ack2), .req(req2), .busy(busy2),
      .done(done2), .pending(pending2), .overflow(overflow2), .timeout_err(timeout_err2)
   );

   always #5 clk = ~clk;

   // Destination-side responder: echoes req after a random delay, or follows ack_man.
   always @(negedge clk) begin
      if (auto_ack) begin
         if (ack != req) begin
            if (ack_dly == 0) begin
               ack     = req;
               ack_dly = $urandom_range(0, 4);
            end else begin
               ack_dly = ack_dly - 1;
            end
         end
      end else begin
         ack = ack_man;
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_want = 0; m_req = 0; m_done = 0; m_ovf = 0; m_pend = 0;
      ackq.delete();
      repeat (SYNC) ackq.push_back(1'b0);
   endtask

   // One clock edge of the transmitter described as events: a launch consumes one
   // queued event, a handshake waits for the delayed ack to rise and then fall.
   task automatic model_step(input bit d, input bit a);
      bit a_s    = ackq[SYNC-1];
      bit launch = !m_busy && (m_pend > 0 || d);
      m_done = 0;
      m_ovf  = 0;
      if (m_busy) begin
         if (m_want && a_s) begin
            m_req  = 0;
            m_want = 0;
         end else if (!m_want && !a_s) begin
            m_busy = 0;
            m_done = 1;
         end
      end else if (launch) begin
         m_busy = 1;
         m_want = 1;
         m_req  = 1;
      end
      if (d && m_pend == MAX_PND && !launch) m_ovf = 1;
      else m_pend = m_pend + int'(d) - int'(launch);
      ackq.push_front(a);
      void'(ackq.pop_back());
   endtask

   task automatic cycle();
      @(posedge clk);
      if (model_on) model_step(din, ack);
      #1;
      if (req && !req_q) rises++;
      if (done) dones++;
      if (req2 && !req2_q) rises2++;
      if (done2) dones2++;
      req_q  = req;
      req2_q = req2;
      if (model_on) begin
         check("m_req", 32'(req), 32'(m_req));
         check("m_busy", 32'(busy), 32'(m_busy));
         check("m_done", 32'(done), 32'(m_done));
         check("m_pending", 32'(pending), 32'(m_pend));
         check("m_overflow", 32'(overflow), 32'(m_ovf));
         check("m_timeout_err", 32'(timeout_err), 32'(0));
      end
   endtask

   task automatic run_until_idle(input string name, input int limit);
      int k = 0;
      while ((busy || pending != 0) && k < limit) begin
         cycle();
         k++;
      end
      check({name, "_idle_in_time"}, 32'(busy || pending != 0), 32'(0));
   endtask

   task automatic wait_rel(input string name);
      int k = 0;
      while (!(busy && !req) && k < 50) begin
         cycle();
         k++;
      end
      check({name, "_reached_rel"}, 32'(busy && !req), 32'(1));
   endtask

   task automatic wait_not_busy(input string name);
      int k = 0;
      while (busy && k < 50) begin
         cycle();
         k++;
      end
      check({name, "_left_busy"}, 32'(busy), 32'(0));
   endtask

   task automatic pulse_reset();
      #2;
      rstn = 1'b0;
      #1;
      @(negedge clk);
      rstn   = 1'b1;
      req_q  = 1'b0;
      req2_q = 1'b0;
      model_reset();
   endtask

   initial begin
      int r0, d0;
      tbl[0] = '{1, 0, 1, 1, 0, 0};
      tbl[1] = '{0, 0, 1, 1, 0, 0};
      tbl[2] = '{0, 0, 1, 1, 0, 0};
      tbl[3] = '{0, 1, 1, 1, 0, 0};
      tbl[4] = '{0, 1, 1, 1, 0, 0};
      tbl[5] = '{0, 1, 0, 1, 0, 0};
      tbl[6] = '{0, 0, 0, 1, 0, 0};
      tbl[7] = '{0, 0, 0, 1, 0, 0};
      tbl[8] = '{0, 0, 0, 0, 1, 0};
      tbl[9] = '{0, 0, 0, 0, 0, 0};

      rstn = 1'b0; din = 1'b0; din2 = 1'b0; ack2 = 1'b0;
      auto_ack = 1'b0; ack_man = 1'b0; model_on = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_req", 32'(req), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_pending", 32'(pending), 32'(0));
      check("rst_overflow", 32'(overflow), 32'(0));
      check("rst_timeout_err", 32'(timeout_err), 32'(0));
      check("rst_small_req", 32'(req2), 32'(0));
      check("rst_small_pending", 32'(pending2), 32'(0));
      rstn = 1'b1;
      cycle();

      // Single event, ack echoed three cycles after req.
      foreach (tbl[i]) begin
         din     = tbl[i].d;
         ack_man = tbl[i].a;
         cycle();
         check($sformatf("tbl%0d_req", i), 32'(req), 32'(tbl[i].e_req));
         check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
         check($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].e_done));
         check($sformatf("tbl%0d_pending", i), 32'(pending), 32'(tbl[i].e_pend));
      end

      // Five back-to-back events while ack is stalled.
      r0 = rises; d0 = dones;
      for (int i = 0; i < 5; i++) begin
         din = 1'b1;
         cycle();
      end
      din = 1'b0;
      check("burst5_pending", 32'(pending), 32'(4));
      auto_ack = 1'b1;
      run_until_idle("burst5", 300);
      check("burst5_req_rises", 32'(rises - r0), 32'(5));
      check("burst5_dones", 32'(dones - d0), 32'(5));

      // Event coincident with a launch from IDLE at pending=2.
      auto_ack = 1'b0; ack_man = 1'b0;
      cycle();
      for (int i = 0; i < 3; i++) begin
         din = 1'b1;
         cycle();
      end
      din = 1'b0;
      ack_man = 1'b1;
      wait_rel("coinc");
      ack_man = 1'b0;
      wait_not_busy("coinc");
      check("coinc_idle_pending", 32'(pending), 32'(2));
      check("coinc_idle_done", 32'(done), 32'(1));
      din = 1'b1;
      cycle();
      din = 1'b0;
      check("coinc_pending_hold", 32'(pending), 32'(2));
      check("coinc_req", 32'(req), 32'(1));
      auto_ack = 1'b1;
      run_until_idle("coinc", 300);

      // Random traffic at two densities, checked every cycle against the model.
      r0 = rises; d0 = dones;
      for (int i = 0; i < 600; i++) begin
         din = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         cycle();
      end
      din = 1'b0;
      run_until_idle("rand", 3000);
      check("rand_done_per_launch", 32'(dones - d0), 32'(rises - r0));

      // Narrow counter saturation with REQ held.
      auto_ack = 1'b0; ack_man = 1'b0;
      din2 = 1'b1;
      cycle();
      check("sat_launch_req", 32'(req2), 32'(1));
      check("sat_launch_pending", 32'(pending2), 32'(0));
      for (int i = 0; i < 6; i++) begin
         din2 = 1'b1;
         cycle();
         check($sformatf("sat%0d_pending", i), 32'(pending2), 32'((i + 1 > 3) ? 3 : i + 1));
         check($sformatf("sat%0d_overflow", i), 32'(overflow2), 32'(i >= 3));
      end
      din2 = 1'b0;
      cycle();
      check("sat_overflow_clear", 32'(overflow2), 32'(0));
      begin
         int k = 0;
         while ((busy2 || pending2 != 0) && k < 300) begin
            ack2 = req2;
            cycle();
            k++;
         end
      end
      check("sat_drained", 32'(busy2 || pending2 != 0), 32'(0));
      check("sat_handshakes", 32'(rises2), 32'(4));
      check("sat_dones", 32'(dones2), 32'(4));
      ack2 = 1'b0;

      // Reset while in REL with three events queued.
      for (int i = 0; i < 4; i++) begin
         din = 1'b1;
         cycle();
      end
      din = 1'b0;
      check("rstrel_pending", 32'(pending), 32'(3));
      ack_man = 1'b1;
      wait_rel("rstrel");
      check("rstrel_pending_in_rel", 32'(pending), 32'(3));
      #2;
      rstn = 1'b0;
      #1;
      check("rstrel_req_async", 32'(req), 32'(0));
      check("rstrel_pending_async", 32'(pending), 32'(0));
      check("rstrel_busy_async", 32'(busy), 32'(0));
      ack_man = 1'b0;
      @(negedge clk);
      rstn   = 1'b1;
      req_q  = 1'b0;
      req2_q = 1'b0;
      model_reset();
      repeat (5) cycle();
      check("rstrel_no_req_after", 32'(req), 32'(0));
      check("rstrel_idle_after", 32'(busy), 32'(0));

`ifdef PULSE_TX_TIMEOUT_EN
      model_on = 1'b0;
      din = 1'b1;
      cycle();
      check("to_launch_req", 32'(req), 32'(1));
      for (int j = 1; j <= TO; j++) begin
         din = (j <= 2 || j == TO);
         cycle();
         if (j < TO) check($sformatf("to_early%0d", j), 32'(timeout_err), 32'(0));
      end
      din = 1'b0;
      check("to_flag", 32'(timeout_err), 32'(1));
      check("to_req", 32'(req), 32'(0));
      check("to_pending", 32'(pending), 32'(0));
      check("to_busy", 32'(busy), 32'(0));
      repeat (5) cycle();
      check("to_sticky", 32'(timeout_err), 32'(1));
      check("to_no_relaunch", 32'(req), 32'(0));
      pulse_reset();
      check("to_cleared_by_reset", 32'(timeout_err), 32'(0));
      model_on = 1'b1;
`else
      din = 1'b1;
      cycle();
      din = 1'b0;
      repeat (40) cycle();
      check("noto_req_held", 32'(req), 32'(1));
      check("noto_busy_held", 32'(busy), 32'(1));
      check("noto_flag", 32'(timeout_err), 32'(0));
      pulse_reset();
`endif
      cycle();
      check("final_idle", 32'(busy), 32'(0));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
